// File: rtl/p_p_pkg.sv
// Shared types, the default channel-to-mask-group map and a map lookup helper
// for the p_p_multi interrupt unit.
package p_p_pkg;

  localparam int P_P_MAP_MAX = 1024;

  // Nibble i is the RM bit index for channel i; 4'hF marks an unmaskable channel.
  localparam logic [127:0] P_P_MGRP32 = 128'h9999_8888_8877_7777_6655_4444_4443_210F;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } pp_state_e;

  function automatic int unsigned mgrp_idx(input logic [P_P_MAP_MAX-1:0] map,
                                           input int unsigned i,
                                           input int unsigned mw);
    logic [P_P_MAP_MAX-1:0] sh;
    sh = map >> (i * mw);
    return sh[31:0] & ((32'd1 << mw) - 32'd1);
  endfunction

endpackage

// File: rtl/p_p_multi_if.sv
// CPU-side bus of the p_p_multi interrupt unit: raw lines, register access,
// and the irq/ack/vector/eoi handshake.
interface p_p_multi_if #(
  parameter int NCH   = 32,
  parameter int NMASK = 10
);
  localparam int VW = (NCH > 1) ? $clog2(NCH) : 1;

  logic [NCH-1:0]   intr;
  logic             rm_we;
  logic [NMASK-1:0] rm_wdata;
  logic [NMASK-1:0] rs;
  logic             rz_we;
  logic [NCH-1:0]   rz_wdata;
  logic             rz_clr;
  logic [NCH-1:0]   rz;
  logic [NCH-1:0]   rp;
  logic             irq;
  logic             ack;
  logic             vec_vld;
  logic [VW-1:0]    vec;
  logic             eoi;

  modport master (
    output intr, rm_we, rm_wdata, rz_we, rz_wdata, rz_clr, ack, eoi,
    input  rs, rz, rp, irq, vec_vld, vec
  );

  modport slave (
    input  intr, rm_we, rm_wdata, rz_we, rz_wdata, rz_clr, ack, eoi,
    output rs, rz, rp, irq, vec_vld, vec
  );

endinterface

// File: rtl/p_p_multi_prio_first.sv
// Lowest-index-set-bit finder: idx is the smallest i with vec[i]=1.
module prio_first #(
  parameter int W  = 32,
  parameter int IW = (W > 1) ? $clog2(W) : 1
) (
  input  logic [W-1:0]  vec,
  output logic          found,
  output logic [IW-1:0] idx
);

  // NOTE: every output of a combinational block gets a default first, so no
  // path through it leaves a value unassigned and infers a latch.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    for (int i = W - 1; i >= 0; i--) begin
      if (vec[i]) begin
        found = 1'b1;
        idx   = IW'(i);
      end
    end
  end

endmodule

// File: rtl/p_p_multi.sv
// Parametrised P-P interrupt unit: request/mask/in-service registers, fixed
// priority arbitration with nesting, and a registered vector handshake.
module p_p_multi
  import p_p_pkg::*;
#(
  parameter int                  NCH   = 32,
  parameter int                  NMASK = 10,
  parameter int                  MW    = 4,
  parameter logic [NCH*MW-1:0]   MGRP  = P_P_MGRP32,
  parameter logic [NCH-1:0]      EDGE  = '0,
  parameter logic [NCH-1:0]      SWW   = 32'hF000_0000
) (
  input  logic        clk,
  input  logic        clm,
  p_p_multi_if.slave  bus
);

  localparam int VW = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int unsigned UNMASK = (1 << MW) - 1;
  localparam logic [P_P_MAP_MAX-1:0] MGRP_EXT = P_P_MAP_MAX'(MGRP);

  pp_state_e        state_q, state_d;
  logic [NCH-1:0]   intr_prev_q, intr_prev_d;
  logic [NCH-1:0]   rz_q, rz_d;
  logic [NCH-1:0]   rp_q, rp_d;
  logic [NMASK-1:0] rs_q, rs_d;
  logic [VW-1:0]    vec_q, vec_d;

  logic [NCH-1:0]   hw_set;
  logic [NCH-1:0]   en;
  logic [NCH-1:0]   cand;
  logic             g_found, top_found;
  logic [VW-1:0]    g_idx, top_idx;
  logic             grant_ok;
  logic             take;

  // Channel enables from the mask-group map, resolved at elaboration.
  for (genvar i = 0; i < NCH; i++) begin : g_en
    localparam int unsigned G = mgrp_idx(MGRP_EXT, i, MW);
    if (G == UNMASK) begin : g_unmask
      assign en[i] = 1'b1;
    end else if (G < NMASK) begin : g_mask
      assign en[i] = rs_q[G];
    end else begin : g_none
      assign en[i] = 1'b0;
    end
  end

  assign hw_set = (EDGE & bus.intr & ~intr_prev_q) | (~EDGE & bus.intr);
  assign cand   = rz_q & en;

  prio_first #(.W(NCH), .IW(VW)) u_grant (
    .vec   (cand),
    .found (g_found),
    .idx   (g_idx)
  );

  prio_first #(.W(NCH), .IW(VW)) u_top (
    .vec   (rp_q),
    .found (top_found),
    .idx   (top_idx)
  );

  // A request only preempts if strictly more urgent than the active handler.
  assign grant_ok = g_found && (!top_found || (g_idx < top_idx));
  assign take     = (state_q == IDLE) && bus.ack && grant_ok;

  always_comb begin
    intr_prev_d = bus.intr;
    rs_d        = bus.rm_we ? bus.rm_wdata : rs_q;
    vec_d       = take ? g_idx : vec_q;
  end

  // Software access first, then hardware sets, then the grant clear last.
  always_comb begin
    rz_d = rz_q;
    if (bus.rz_we) begin
      rz_d = (rz_d & ~SWW) | (bus.rz_wdata & SWW);
    end
    if (bus.rz_clr) begin
      rz_d = rz_d & ~SWW;
    end
    rz_d = rz_d | hw_set;
    if (take) begin
      rz_d[g_idx] = 1'b0;
    end
  end

  // The eoi target comes from rp_q, so a same-cycle grant cannot be retired.
  always_comb begin
    rp_d = rp_q;
    if (bus.eoi && top_found) begin
      rp_d[top_idx] = 1'b0;
    end
    if (take) begin
      rp_d[g_idx] = 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (take) state_d = GRANT;
      GRANT:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.vec_vld = (state_q == GRANT);
    bus.irq     = (state_q == IDLE) && grant_ok;
  end

  assign bus.vec = vec_q;
  assign bus.rs  = rs_q;
  assign bus.rz  = rz_q;
  assign bus.rp  = rp_q;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (clm) begin
      state_q     <= IDLE;
      // NOTE: history takes the live lines on reset so already-high inputs do
      // not look like fresh edges once clm drops.
      intr_prev_q <= bus.intr;
      rz_q        <= '0;
      rp_q        <= '0;
      rs_q        <= '0;
      vec_q       <= '0;
    end else begin
      state_q     <= state_d;
      intr_prev_q <= intr_prev_d;
      rz_q        <= rz_d;
      rp_q        <= rp_d;
      rs_q        <= rs_d;
      vec_q       <= vec_d;
    end
  end

endmodule

// File: tb/tb_p_p_multi.sv
// Directed self-checking bench for p_p_multi: grant, masking, nesting,
// edge/level, software channels, eoi/mask races and reset mid-grant.
module tb_p_p_multi;
  import p_p_pkg::*;

  localparam int NCH   = 32;
  localparam int NMASK = 10;
  localparam logic [NCH-1:0] EDGE_CFG = 32'h0000_0200;
  localparam logic [NCH-1:0] SWW_CFG  = 32'hF000_0000;

  logic clk = 1'b0;
  logic clm;
  int   total = 0;
  int   bad   = 0;

  p_p_multi_if #(.NCH(NCH), .NMASK(NMASK)) bus ();

  p_p_multi #(
    .NCH   (NCH),
    .NMASK (NMASK),
    .MW    (4),
    .MGRP  (P_P_MGRP32),
    .EDGE  (EDGE_CFG),
    .SWW   (SWW_CFG)
  ) dut (
    .clk (clk),
    .clm (clm),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  initial begin
    int cnt;
    bus.intr     = '0;
    bus.rm_we    = 1'b0;
    bus.rm_wdata = '0;
    bus.rz_we    = 1'b0;
    bus.rz_wdata = '0;
    bus.rz_clr   = 1'b0;
    bus.ack      = 1'b0;
    bus.eoi      = 1'b0;
    clm          = 1'b1;
    tick(2);
    check("rst_rs", bus.rs, 0);
    check("rst_rz", bus.rz, 0);
    check("rst_rp", bus.rp, 0);
    check("rst_irq", bus.irq, 0);
    check("rst_vld", bus.vec_vld, 0);
    check("rst_vec", bus.vec, 0);
    clm = 1'b0;

    // Basic grant of level channel 5
    bus.rm_we = 1'b1; bus.rm_wdata = 10'h3FF;
    tick(); bus.rm_we = 1'b0;
    check("t1_rs", bus.rs, 10'h3FF);
    bus.intr = 32'h0000_0020;
    tick(); bus.intr = '0;
    check("t1_rz", bus.rz, 32'h0000_0020);
    check("t1_irq", bus.irq, 1);
    bus.ack = 1'b1;
    tick(); bus.ack = 1'b0;
    check("t1_vld", bus.vec_vld, 1);
    check("t1_vec", bus.vec, 5);
    check("t1_rp", bus.rp, 32'h0000_0020);
    check("t1_rz_clr", bus.rz, 0);
    check("t1_irq_gr", bus.irq, 0);
    tick();
    check("t1_vld_drop", bus.vec_vld, 0);
    check("t1_irq_idle", bus.irq, 0);
    bus.eoi = 1'b1;
    tick(); bus.eoi = 1'b0;
    check("t1_eoi", bus.rp, 0);

    // Masking: rs[4]=0 blocks channel 7, unmask raises irq, ch0 unmaskable
    bus.rm_we = 1'b1; bus.rm_wdata = 10'h3EF; bus.intr = 32'h0000_0080;
    tick(); bus.rm_we = 1'b0; bus.intr = '0;
    check("t2_rz7", bus.rz, 32'h0000_0080);
    check("t2_irq_masked", bus.irq, 0);
    bus.rm_we = 1'b1; bus.rm_wdata = 10'h3FF;
    tick(); bus.rm_we = 1'b0;
    check("t2_irq_unmasked", bus.irq, 1);
    bus.ack = 1'b1;
    tick(); bus.ack = 1'b0;
    check("t2_vec7", bus.vec, 7);
    bus.eoi = 1'b1;
    tick(); bus.eoi = 1'b0;
    check("t2_rp_clr", bus.rp, 0);
    check("t2_rz_clr", bus.rz, 0);
    bus.rm_we = 1'b1; bus.rm_wdata = '0; bus.intr = 32'h0000_0001;
    tick(); bus.rm_we = 1'b0; bus.intr = '0;
    check("t2_rs0", bus.rs, 0);
    check("t2_irq_ch0", bus.irq, 1);
    bus.ack = 1'b1;
    tick(); bus.ack = 1'b0;
    check("t2_vec0", bus.vec, 0);
    check("t2_vld0", bus.vec_vld, 1);
    bus.eoi = 1'b1;
    tick(); bus.eoi = 1'b0;
    check("t2_rp0_clr", bus.rp, 0);

    // Nesting: ch12 active, ch3 preempts, ch20 held until both retire
    bus.rm_we = 1'b1; bus.rm_wdata = 10'h3FF; bus.intr = 32'h0000_1000;
    tick(); bus.rm_we = 1'b0; bus.intr = '0;
    check("t3_irq12", bus.irq, 1);
    bus.ack = 1'b1;
    tick(); bus.ack = 1'b0;
    check("t3_vec12", bus.vec, 12);
    check("t3_rp12", bus.rp, 32'h0000_1000);
    bus.intr = 32'h0010_0008;
    tick(); bus.intr = '0;
    check("t3_rz_3_20", bus.rz, 32'h0010_0008);
    check("t3_irq_nest", bus.irq, 1);
    bus.ack = 1'b1;
    tick(); bus.ack = 1'b0;
    check("t3_vec3", bus.vec, 3);
    check("t3_rp_3_12", bus.rp, 32'h0000_1008);
    check("t3_rz20", bus.rz, 32'h0010_0000);
    tick();
    check("t3_irq_blk", bus.irq, 0);
    bus.eoi = 1'b1;
    tick(); bus.eoi = 1'b0;
    check("t3_eoi1_rp", bus.rp, 32'h0000_1000);
    check("t3_eoi1_irq", bus.irq, 0);
    bus.eoi = 1'b1;
    tick(); bus.eoi = 1'b0;
    check("t3_eoi2_rp", bus.rp, 0);
    check("t3_eoi2_irq", bus.irq, 1);
    bus.ack = 1'b1;
    tick(); bus.ack = 1'b0;
    check("t3_vec20", bus.vec, 20);
    bus.eoi = 1'b1;
    tick(); bus.eoi = 1'b0;
    check("t3_rp_done", bus.rp, 0);

    // eoi in the same cycle as a grant retires the pre-grant top (ch12)
    bus.intr = 32'h0000_1000;
    tick(); bus.intr = '0;
    bus.ack = 1'b1;
    tick(); bus.ack = 1'b0;
    bus.intr = 32'h0000_0008;
    tick(); bus.intr = '0;
    bus.ack = 1'b1; bus.eoi = 1'b1;
    tick(); bus.ack = 1'b0; bus.eoi = 1'b0;
    check("t3_race_vec", bus.vec, 3);
    check("t3_race_rp", bus.rp, 32'h0000_0008);
    bus.eoi = 1'b1;
    tick(); bus.eoi = 1'b0;
    check("t3_race_clr", bus.rp, 0);

    // Level ch8 held 10 cycles re-requests after every grant
    bus.intr = 32'h0000_0100; bus.ack = 1'b1; bus.eoi = 1'b1;
    cnt = 0;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (bus.vec_vld) cnt++;
    end
    bus.intr = '0; bus.ack = 1'b0; bus.eoi = 1'b0;
    check("t4_level_grants", cnt, 5);
    bus.eoi = 1'b1;
    tick(); bus.eoi = 1'b0;
    check("t4_level_rp", bus.rp, 0);
    check("t4_level_rz", bus.rz, 0);

    // Edge ch9 held 10 cycles fires once
    bus.intr = 32'h0000_0200; bus.ack = 1'b1; bus.eoi = 1'b1;
    cnt = 0;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (bus.vec_vld) cnt++;
    end
    bus.intr = '0; bus.ack = 1'b0; bus.eoi = 1'b0;
    check("t4_edge_grants", cnt, 1);
    check("t4_edge_rz", bus.rz, 0);
    check("t4_edge_rp", bus.rp, 0);

    // Software channels: write reaches only 28..31, hardware set beats clear
    bus.rz_we = 1'b1; bus.rz_wdata = 32'hFFFF_FFFF;
    tick(); bus.rz_we = 1'b0;
    check("t5_sw_write", bus.rz, 32'hF000_0000);
    check("t5_sw_irq", bus.irq, 1);
    bus.rz_clr = 1'b1; bus.intr = 32'h4000_0000;
    tick(); bus.rz_clr = 1'b0; bus.intr = '0;
    check("t5_set_beats_clr", bus.rz, 32'h4000_0000);
    bus.rz_we = 1'b1; bus.rz_clr = 1'b1;
    tick(); bus.rz_we = 1'b0; bus.rz_clr = 1'b0;
    check("t5_clr_wins", bus.rz, 0);

    // Same-cycle mask write does not affect the grant
    bus.intr = 32'h0000_0020;
    tick(); bus.intr = '0;
    bus.ack = 1'b1; bus.rm_we = 1'b1; bus.rm_wdata = '0;
    tick(); bus.ack = 1'b0; bus.rm_we = 1'b0;
    check("t5_mask_race_vld", bus.vec_vld, 1);
    check("t5_mask_race_vec", bus.vec, 5);
    check("t5_mask_race_rs", bus.rs, 0);
    bus.eoi = 1'b1;
    tick(); bus.eoi = 1'b0;
    check("t5_mask_race_rp", bus.rp, 0);

    // Edge line high through reset does not fire afterwards
    bus.intr = 32'h0000_0200; clm = 1'b1;
    tick(); clm = 1'b0;
    tick();
    check("t6_edge_hist_rz", bus.rz, 0);
    check("t6_edge_hist_irq", bus.irq, 0);
    bus.intr = '0;

    // Reset during GRANT
    bus.rm_we = 1'b1; bus.rm_wdata = 10'h3FF; bus.intr = 32'h0000_0003;
    tick(); bus.rm_we = 1'b0; bus.intr = '0;
    check("t6_rz_pend", bus.rz, 32'h0000_0003);
    bus.ack = 1'b1;
    tick(); bus.ack = 1'b0;
    check("t6_grant_vld", bus.vec_vld, 1);
    check("t6_grant_vec", bus.vec, 0);
    clm = 1'b1;
    tick(); clm = 1'b0;
    check("t6_rst_vld", bus.vec_vld, 0);
    check("t6_rst_rz", bus.rz, 0);
    check("t6_rst_rp", bus.rp, 0);
    check("t6_rst_rs", bus.rs, 0);
    check("t6_rst_irq", bus.irq, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
